oc8051_ice_leds: RTL and testbench
==================================

Name: oc8051_ice_leds

Overview:
- Board-level LED activity generator for the iCE FPGA build of the oc8051 platform.
- Drives five board LEDs from a single clock:
  - o_led4 is a heartbeat.
  - o_led3..o_led0 step through a fixed 8-entry pattern table.
- A programmable prescaler sets the step rate, giving a visible "board alive" indication with no software running.

Parameters:
- TICK_DIV, 1000000: clock cycles per step tick. Legal range is 2 to 2^24. Counter width is $clog2(TICK_DIV).

Ports:
- i_clk  input  1  system clock, rising-edge active.
- i_rst  input  1  reset, asynchronous, active-high.
- o_led4  output  1  heartbeat LED; toggles on every tick.
- o_led3  output  1  pattern bit 3.
- o_led2  output  1  pattern bit 2.
- o_led1  output  1  pattern bit 1.
- o_led0  output  1  pattern bit 0.

Behaviour:
- One clock domain (i_clk). Reset is asynchronous and active-high. All state resets immediately on i_rst=1, independent of the clock.
- Reset values:
  - prescaler cnt=0, step=0, heartbeat=0.
  - o_led4=0.
  - {o_led3..o_led0}=4'b0001 (PAT[0]).
- Prescaler:
  - cnt increments every clock.
  - When cnt==TICK_DIV-1, tick=1 for that cycle and cnt wraps to 0 on the next edge.
  - The first tick occurs on the TICK_DIV-th rising edge after reset deassertion.
- Pattern table PAT[0..7], bits [3:0] = led3..led0: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
- On the tick edge:
  - step <= step+1, 3-bit, wraps 7 to 0.
  - LED register <= PAT[step+1 mod 8].
  - heartbeat <= ~heartbeat.
- All outputs are driven directly from flops, with no combinational decode on the pins. Update latency is exactly one edge after the tick cycle, i.e. the tick edge itself.
- Full pattern period is 8*TICK_DIV cycles. Heartbeat period is 2*TICK_DIV cycles.
- Reset asserted mid-sequence: outputs return to reset values immediately. The sequence restarts from PAT[0], and the full TICK_DIV interval is counted before the next tick.
- Reset deasserted coincident with a clock edge: that edge does not count. cnt remains 0.
- No other inputs exist. The block runs freely forever after reset.

Optional Feature:
- Macro: OC8051_ICE_SWEEP_EN.
- Defined: the pattern table is replaced by a bouncing single-LED sweep.
  - A 2-bit position pos and a direction flag are used. Reset: pos=0, direction up.
  - Position sequence per tick: 0,1,2,3,2,1, then repeats (6-tick period).
  - Direction reverses at pos 3 and at pos 0.
  - Output is one-hot: o_led[pos]=1, all other pattern LEDs 0. Reset output is 0001.
  - Heartbeat and prescaler behaviour are unchanged.
- Undefined: 8-entry table behaviour as above. No sweep logic is synthesised.

Test Plan (TICK_DIV=4, 20 ns clock):
- Hold i_rst=1 for 17 ns, then release -> o_led4=0 and led3..0=0001 throughout reset and for the first 3 edges after release.
- 4th rising edge after release -> led3..0=0011 and o_led4=1. 8th edge -> 0111 and o_led4=0.
- Run 32 edges (8 ticks) -> led3..0 has visited all 8 PAT entries in order and is back at 0001. o_led4=0.
- Assert i_rst asynchronously between edges while led3..0=1110 -> outputs become 0001 / o_led4=0 before the next edge. After release, the next change occurs exactly 4 edges later.
- Run 5000 cycles (100 us) -> exactly 1250 ticks occur. o_led4 toggles 1250 times and never glitches between edges.
- With OC8051_ICE_SWEEP_EN defined, 12 ticks -> led3..0 sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100, 1000, 0100, 0010, 0001 (reset value followed by the 12 ticks).

Source files
------------

// File: rtl/oc8051_ice_leds.sv
// oc8051_ice_leds: board "alive" LED generator for the iCE build of oc8051.
// A prescaler produces one tick every TICK_DIV clocks. Each tick toggles the
// heartbeat LED and advances the four pattern LEDs.
// Optional macro OC8051_ICE_SWEEP_EN swaps the 8-entry pattern table for a
// bouncing single-LED sweep. With the macro undefined the table is used.
module oc8051_ice_leds #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_led4,
  output logic o_led3,
  output logic o_led2,
  output logic o_led1,
  output logic o_led0
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic             hb_q, hb_d;
  logic [3:0]       led_q, led_d;

  // Prescaler: count every clock and flag the last count of each interval
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : (cnt_q + CNT_ONE);
    hb_d  = tick ? ~hb_q : hb_q;
  end

  // Prescaler and heartbeat registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
      hb_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hb_q  <= hb_d;
    end
  end

`ifdef OC8051_ICE_SWEEP_EN

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  logic [1:0] pos_q, pos_d;
  dir_t       dir_q, dir_d;

  // Sweep: step the lit LED one place per tick, bouncing at both ends
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    led_d = led_q;
    if (tick) begin
      pos_d = (dir_q == DIR_UP) ? (pos_q + 2'd1) : (pos_q - 2'd1);
      if (pos_d == 2'd3) begin
        dir_d = DIR_DOWN;
      end else if (pos_d == 2'd0) begin
        dir_d = DIR_UP;
      end
      led_d = 4'b0001 << pos_d;
    end
  end

  // Sweep position, direction and LED registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pos_q <= 2'd0;
      dir_q <= DIR_UP;
      led_q <= 4'b0001;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
      led_q <= led_d;
    end
  end

`else

  logic [2:0] step_q, step_d;

  function automatic logic [3:0] patLookup(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b0001;
      3'd1:    pat = 4'b0011;
      3'd2:    pat = 4'b0111;
      3'd3:    pat = 4'b1111;
      3'd4:    pat = 4'b1110;
      3'd5:    pat = 4'b1100;
      3'd6:    pat = 4'b1000;
      default: pat = 4'b0000;
    endcase
    return pat;
  endfunction

  // Table walk: on each tick load the next entry so the pins stay flop-driven
  always_comb begin
    step_d = step_q;
    led_d  = led_q;
    if (tick) begin
      step_d = step_q + 3'd1;
      led_d  = patLookup(step_d);
    end
  end

  // Step index and LED registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      step_q <= 3'd0;
      led_q  <= 4'b0001;
    end else begin
      step_q <= step_d;
      led_q  <= led_d;
    end
  end

`endif

  assign o_led4 = hb_q;
  assign o_led3 = led_q[3];
  assign o_led2 = led_q[2];
  assign o_led1 = led_q[1];
  assign o_led0 = led_q[0];

endmodule

// File: tb/tb_oc8051_ice_leds.sv
// Testbench for oc8051_ice_leds with TICK_DIV=4 and a 20 ns clock.
// Expected LED values follow the sweep sequence when OC8051_ICE_SWEEP_EN is
// defined, and the 8-entry pattern table otherwise.
module tb_oc8051_ice_leds;

  typedef struct {
    int         edges;
    logic [3:0] expLed;
    logic       expHb;
  } vec_t;

  logic clk;
  logic rst;
  logic led4, led3, led2, led1, led0;
  logic [3:0] ledBus;

  int checks;
  int failures;
  bit counting;
  int hbEvents;

  vec_t vecs[9];

  oc8051_ice_leds #(.TICK_DIV(4)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .o_led4 (led4),
    .o_led3 (led3),
    .o_led2 (led2),
    .o_led1 (led1),
    .o_led0 (led0)
  );

  assign ledBus = {led3, led2, led1, led0};

  // Free-running 20 ns clock, first rising edge at 10 ns
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Count every heartbeat transition so any glitch shows up as an extra event
  always @(led4) begin
    if (counting) hbEvents++;
  end

  task automatic checkOutput(input string name, input logic [3:0] expLed, input logic expHb);
    checks++;
    if (ledBus !== expLed || led4 !== expHb) begin
      failures++;
      $display("[TB] FAIL %s: got led=%b hb=%b, expected led=%b hb=%b",
               name, ledBus, led4, expLed, expHb);
    end
  endtask

  task automatic checkCount(input string name, input int got, input int expected);
    checks++;
    if (got != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expected);
    end
  endtask

  task automatic applyStimulus(input int nEdges);
    repeat (nEdges) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] prevLed;
    logic       prevHb;
    logic [3:0] preResetLed;
    logic [3:0] firstTickLed;
    int         sampledHbToggles;
    int         sampledLedChanges;

    checks   = 0;
    failures = 0;
    counting = 1'b0;
    hbEvents = 0;

`ifdef OC8051_ICE_SWEEP_EN
    vecs[0] = '{3, 4'b0001, 1'b0};
    vecs[1] = '{1, 4'b0010, 1'b1};
    vecs[2] = '{4, 4'b0100, 1'b0};
    vecs[3] = '{4, 4'b1000, 1'b1};
    vecs[4] = '{4, 4'b0100, 1'b0};
    vecs[5] = '{4, 4'b0010, 1'b1};
    vecs[6] = '{4, 4'b0001, 1'b0};
    vecs[7] = '{4, 4'b0010, 1'b1};
    vecs[8] = '{4, 4'b0100, 1'b0};
    preResetLed  = 4'b0001;
    firstTickLed = 4'b0010;
`else
    vecs[0] = '{3, 4'b0001, 1'b0};
    vecs[1] = '{1, 4'b0011, 1'b1};
    vecs[2] = '{4, 4'b0111, 1'b0};
    vecs[3] = '{4, 4'b1111, 1'b1};
    vecs[4] = '{4, 4'b1110, 1'b0};
    vecs[5] = '{4, 4'b1100, 1'b1};
    vecs[6] = '{4, 4'b1000, 1'b0};
    vecs[7] = '{4, 4'b0000, 1'b1};
    vecs[8] = '{4, 4'b0001, 1'b0};
    preResetLed  = 4'b1110;
    firstTickLed = 4'b0011;
`endif

    // Asynchronous reset held for 17 ns, released between edges
    rst = 1'b1;
    #5;
    checkOutput("reset_hold", 4'b0001, 1'b0);
    #12;
    rst = 1'b0;

    // Walk the table, checking every edge: holds before the tick, new value on it
    prevLed = 4'b0001;
    prevHb  = 1'b0;
    for (int v = 0; v < 9; v++) begin
      for (int k = 1; k <= vecs[v].edges; k++) begin
        applyStimulus(1);
        if (k < vecs[v].edges) checkOutput($sformatf("hold_v%0d_e%0d", v, k), prevLed, prevHb);
        else                   checkOutput($sformatf("step_v%0d", v), vecs[v].expLed, vecs[v].expHb);
      end
      prevLed = vecs[v].expLed;
      prevHb  = vecs[v].expHb;
    end

    // Four more ticks, then reset asynchronously between edges
    applyStimulus(16);
    checkOutput("pre_reset", preResetLed, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 4'b0001, 1'b0);
    applyStimulus(1);
    checkOutput("reset_over_edge", 4'b0001, 1'b0);
    rst = 1'b0;

    // After release the full interval must elapse before the next change
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("post_reset_hold_e%0d", k), 4'b0001, 1'b0);
    end
    applyStimulus(1);
    checkOutput("post_reset_tick", firstTickLed, 1'b1);

    // 5000-cycle window: exactly 1250 ticks and no spurious heartbeat events
    sampledHbToggles  = 0;
    sampledLedChanges = 0;
    prevLed  = ledBus;
    prevHb   = led4;
    hbEvents = 0;
    counting = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      applyStimulus(1);
      if (led4 !== prevHb) sampledHbToggles++;
      if (ledBus !== prevLed) sampledLedChanges++;
      prevHb  = led4;
      prevLed = ledBus;
    end
    counting = 1'b0;
    checkCount("hb_toggles_sampled", sampledHbToggles, 1250);
    checkCount("hb_events", hbEvents, 1250);
    checkCount("led_changes", sampledLedChanges, 1250);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
